tank_inlet_valve_controller: RTL and testbench

- Consumer side of the tank level counter: takes the 3-bit water level and drives the tank inlet valve with hysteresis.
- Refills when level drops to LOW_LEVEL; stops at HIGH_LEVEL; holds a settle window to stop valve chatter.
- Raises a latched fault when the level fails to rise during filling (dry source or stuck sensor).
- Gates the irrigation outlet so it only runs when enough water is present.

---
 rtl/tank_inlet_valve_controller_if.sv | 31 +++
 rtl/tank_inlet_valve_controller.sv | 117 +++++++++++
 tb/tb_tank_inlet_valve_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tank_inlet_valve_controller_if.sv
// Level-sensor / valve / outlet signal bundle between irrigation logic and the inlet valve controller.
// master drives level and requests; slave (the controller) drives valve, outlet gate, fault and state.
interface tank_inlet_valve_controller_if;
  logic [2:0] level;
  logic       irrigate_req;
  logic       fault_clear;
  logic       inlet_valve;
  logic       outlet_enable;
  logic       fault;
  logic [1:0] state;

  modport master (
    output level,
    output irrigate_req,
    output fault_clear,
    input  inlet_valve,
    input  outlet_enable,
    input  fault,
    input  state
  );

  modport slave (
    input  level,
    input  irrigate_req,
    input  fault_clear,
    output inlet_valve,
    output outlet_enable,
    output fault,
    output state
  );
endinterface

// File: rtl/tank_inlet_valve_controller.sv
// Hysteretic tank inlet valve FSM with fill-timeout fault latch and gated irrigation outlet.
// Latency: valve/fault are a Moore decode of the state register (1 edge); outlet_enable is registered (1 edge).
// Backpressure: none; level is sampled every edge and outputs never stall.
module tank_inlet_valve_controller #(
  parameter int LOW_LEVEL     = 2,
  parameter int HIGH_LEVEL    = 6,
  parameter int MIN_LEVEL     = 1,
  parameter int FILL_TIMEOUT  = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  tank_inlet_valve_controller_if.slave      bus
);

  localparam int MAX_CNT = (FILL_TIMEOUT > SETTLE_CYCLES) ? FILL_TIMEOUT : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [2:0]    LOW_L      = 3'(LOW_LEVEL);
  localparam logic [2:0]    HIGH_L     = 3'(HIGH_LEVEL);
  localparam logic [2:0]    MIN_L      = 3'(MIN_LEVEL);
  localparam logic [CW-1:0] TMO_LAST   = CW'(FILL_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    SETTLE = 2'b10,
    FAULT  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    peak_q, peak_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;
  logic          outlet_q, outlet_d;

  // Counters hold at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    peak_d       = peak_q;
    tmo_cnt_d    = tmo_cnt_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.level <= LOW_L) begin
          state_d   = FILL;
          peak_d    = bus.level;
          tmo_cnt_d = '0;
        end
      end

      FILL: begin
        // Reaching the high mark wins over a timeout landing on the same edge.
        if (bus.level >= HIGH_L) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end else if (bus.level > peak_q) begin
          peak_d    = bus.level;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = FAULT;
        end else begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_END) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = sat_inc(settle_cnt_q);
        end
      end

      FAULT: begin
        if (bus.fault_clear) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Uses next state so the outlet shuts on the very edge the fault latches.
    outlet_d = bus.irrigate_req && (bus.level >= MIN_L) && (state_d != FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      peak_q       <= '0;
      tmo_cnt_q    <= '0;
      settle_cnt_q <= '0;
      outlet_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      peak_q       <= peak_d;
      tmo_cnt_q    <= tmo_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      outlet_q     <= outlet_d;
    end
  end

  assign bus.inlet_valve   = (state_q == FILL);
  assign bus.fault         = (state_q == FAULT);
  assign bus.outlet_enable = outlet_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_tank_inlet_valve_controller.sv
// Directed bench for the tank inlet valve controller; expected outputs queued at drive time, checked after each edge.
module tb_tank_inlet_valve_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;

  tank_inlet_valve_controller_if bus ();

  tank_inlet_valve_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       iv;
    logic       oe;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_FILL = 2'b01, S_SETTLE = 2'b10, S_FAULT = 2'b11;

  task automatic push_exp(input string tag, input logic [1:0] st, input logic iv,
                          input logic oe, input logic flt);
    exp_t e;
    e.tag = tag; e.st = st; e.iv = iv; e.oe = oe; e.flt = flt;
    exp_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t       e;
    logic [4:0] got, want;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: got no entry want one");
      return;
    end
    e    = exp_q.pop_front();
    got  = {bus.state, bus.inlet_valve, bus.outlet_enable, bus.fault};
    want = {e.st, e.iv, e.oe, e.flt};
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got state=%b valve=%b outlet=%b fault=%b want state=%b valve=%b outlet=%b fault=%b",
             e.tag, got[4:3], got[2], got[1], got[0], e.st, e.iv, e.oe, e.flt);
    end
  endtask

  // Called at posedge+1: drive inputs, queue expectation, take one edge, check.
  task automatic step(input logic [2:0] lv, input logic irq, input logic fc,
                      input logic [1:0] st, input logic iv, input logic oe, input logic flt,
                      input string tag);
    bus.level        = lv;
    bus.irrigate_req = irq;
    bus.fault_clear  = fc;
    push_exp(tag, st, iv, oe, flt);
    @(posedge clock);
    #1;
    check_front();
  endtask

  initial begin
    bus.level        = 3'd3;
    bus.irrigate_req = 1'b0;
    bus.fault_clear  = 1'b0;

    #12;
    push_exp("reset_state", S_IDLE, 1'b0, 1'b0, 1'b0);
    check_front();
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Idle above low mark, then cross it.
    for (int i = 0; i < 3; i++) step(3'd3, 0, 0, S_IDLE, 0, 0, 0, "idle_hold");
    step(3'd2, 0, 0, S_FILL, 1, 0, 0, "fill_enter");

    // Level rising one step every 5 cycles: never times out.
    for (int i = 0; i < 4; i++) step(3'd2, 0, 0, S_FILL, 1, 0, 0, "fill_lvl2");
    for (int lv = 3; lv <= 5; lv++)
      for (int i = 0; i < 5; i++) step(3'(lv), 0, 0, S_FILL, 1, 0, 0, "fill_rising");
    step(3'd6, 0, 0, S_SETTLE, 0, 0, 0, "settle_enter");
    for (int i = 0; i < 3; i++) step(3'd6, 0, 0, S_SETTLE, 0, 0, 0, "settle_hold");
    step(3'd6, 0, 0, S_IDLE, 0, 0, 0, "settle_done");

    // Stuck level: fault exactly 16 edges after fill entry.
    step(3'd2, 0, 0, S_FILL, 1, 0, 0, "stuck_enter");
    for (int i = 0; i < 15; i++) step(3'd2, 0, 0, S_FILL, 1, 0, 0, "stuck_fill");
    step(3'd2, 0, 0, S_FAULT, 0, 0, 1, "fault_enter");
    step(3'd2, 0, 0, S_FAULT, 0, 0, 1, "fault_hold");
    step(3'd2, 0, 1, S_IDLE, 0, 0, 0, "fault_clear");
    step(3'd2, 0, 0, S_FILL, 1, 0, 0, "refill_enter");

    // Timeout and high mark on the same edge: high mark wins.
    for (int i = 0; i < 15; i++) step(3'd2, 0, 0, S_FILL, 1, 0, 0, "prio_fill");
    step(3'd6, 0, 0, S_SETTLE, 0, 0, 0, "prio_settle");
    for (int i = 0; i < 3; i++) step(3'd3, 0, 0, S_SETTLE, 0, 0, 0, "prio_settle_hold");
    step(3'd3, 0, 0, S_IDLE, 0, 0, 0, "prio_idle");
    step(3'd3, 0, 1, S_IDLE, 0, 0, 0, "clear_ignored");

    // Outlet gating follows level one cycle late.
    step(3'd0, 1, 0, S_FILL, 1, 0, 0, "outlet_lvl0");
    step(3'd1, 1, 0, S_FILL, 1, 1, 0, "outlet_lvl1");
    step(3'd0, 1, 0, S_FILL, 1, 0, 0, "outlet_lvl0_again");
    step(3'd5, 1, 0, S_FILL, 1, 1, 0, "outlet_lvl5");
    for (int i = 0; i < 15; i++) step(3'd5, 1, 0, S_FILL, 1, 1, 0, "outlet_fill");
    step(3'd5, 1, 0, S_FAULT, 0, 0, 1, "outlet_fault_enter");
    step(3'd5, 1, 0, S_FAULT, 0, 0, 1, "outlet_fault_hold");
    step(3'd5, 1, 1, S_IDLE, 0, 1, 0, "outlet_after_clear");
    step(3'd3, 0, 0, S_IDLE, 0, 0, 0, "outlet_req_drop");

    // Asynchronous reset mid-fill.
    step(3'd2, 1, 0, S_FILL, 1, 1, 0, "rst_fill_enter");
    step(3'd2, 1, 0, S_FILL, 1, 1, 0, "rst_fill_hold");
    #2;
    reset = 1'b0;
    #1;
    push_exp("rst_async", S_IDLE, 0, 0, 0);
    check_front();
    @(posedge clock);
    #1;
    bus.level = 3'd7;
    reset     = 1'b1;
    step(3'd7, 0, 0, S_IDLE, 0, 0, 0, "rst_release_full");
    step(3'd7, 1, 0, S_IDLE, 0, 1, 0, "idle_full_outlet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
